// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, default
// datapath widths and the legal range of the ALU latency counter.
package alu_seq_pkg;

  localparam int unsigned W_DEF       = 8;
  localparam int unsigned OPW_DEF     = 4;
  localparam int unsigned KW_DEF      = 2;
  localparam int unsigned ALU_LAT_DEF = 1;
  localparam int unsigned ALU_LAT_MAX = 15;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_sequencer_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, purely combinational.
// Ports:
//   vld    - request valid per requester
//   last   - requester granted most recently
//   gnt    - one-hot grant (zero when nothing is valid)
//   gnt_id - index of the granted requester
module rr_arb2 (
  input  logic [1:0] vld,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    gnt_id = 1'b0;
    unique case (vld)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last;
      default: gnt_id = 1'b0;
    endcase
    gnt = vld & (gnt_id ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: shares one ALU between two requesters, one operation in
// flight, round-robin arbitration, fixed ALU latency.
// Ports:
//   CLK, RST                    - clock, asynchronous active-low reset
//   REQ_VLD/REQ_RDY             - request handshake per requester
//   REQ_OPT/REQ_A/REQ_B/REQ_KEY - per-requester opcode, operands, key
//   RSP_VLD/RSP_RDY/RSP_ID/RSP_Z - response handshake, owner and result
//   ALU_ENA/OPT/RGA/RGB/KEY     - registered ALU drive
//   ALU_RGZ                     - ALU result
//   BUSY                        - sequencer not idle
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned OPW     = OPW_DEF,
  parameter int unsigned KW      = KW_DEF,
  parameter int unsigned ALU_LAT = ALU_LAT_DEF  // 1..ALU_LAT_MAX
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [1:0]      REQ_VLD,
  output logic [1:0]      REQ_RDY,
  input  logic [2*OPW-1:0] REQ_OPT,
  input  logic [2*W-1:0]  REQ_A,
  input  logic [2*W-1:0]  REQ_B,
  input  logic [2*KW-1:0] REQ_KEY,
  output logic            RSP_VLD,
  input  logic            RSP_RDY,
  output logic            RSP_ID,
  output logic [W-1:0]    RSP_Z,
  output logic            ALU_ENA,
  output logic [OPW-1:0]  ALU_OPT,
  output logic [W-1:0]    ALU_RGA,
  output logic [W-1:0]    ALU_RGB,
  output logic [KW-1:0]   ALU_KEY,
  input  logic [W-1:0]    ALU_RGZ,
  output logic            BUSY
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ena_q, ena_d;
  logic [OPW-1:0]   opt_q, opt_d;
  logic [W-1:0]     rga_q, rga_d;
  logic [W-1:0]     rgb_q, rgb_d;
  logic [KW-1:0]    key_q, key_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic             rsp_id_q, rsp_id_d;
  logic [W-1:0]     rsp_z_q, rsp_z_d;
  logic             busy_q, busy_d;

  logic [1:0] arb_gnt;
  logic       arb_id;

  rr_arb2 u_arb (
    .vld    (REQ_VLD),
    .last   (last_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // Ready only while idle; forced low while reset is held so all outputs read 0.
  assign REQ_RDY = (state_q == IDLE && RST) ? arb_gnt : 2'b00;

  // Next-state and datapath capture.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ena_d     = ena_q;
    opt_d     = opt_q;
    rga_d     = rga_q;
    rgb_d     = rgb_q;
    key_d     = key_q;
    rsp_vld_d = rsp_vld_q;
    rsp_id_d  = rsp_id_q;
    rsp_z_d   = rsp_z_q;
    unique case (state_q)
      IDLE: begin
        if (|REQ_VLD) begin
          opt_d    = arb_id ? REQ_OPT[OPW +: OPW] : REQ_OPT[0 +: OPW];
          rga_d    = arb_id ? REQ_A[W +: W]       : REQ_A[0 +: W];
          rgb_d    = arb_id ? REQ_B[W +: W]       : REQ_B[0 +: W];
          key_d    = arb_id ? REQ_KEY[KW +: KW]   : REQ_KEY[0 +: KW];
          rsp_id_d = arb_id;
          ena_d    = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last latency cycle: result is valid now, capture it.
        if (cnt_q == CNT_W'(1)) begin
          rsp_z_d   = ALU_RGZ;
          rsp_vld_d = 1'b1;
          ena_d     = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (RSP_RDY) begin
          rsp_vld_d = 1'b0;
          last_d    = rsp_id_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      ena_q     <= 1'b0;
      opt_q     <= '0;
      rga_q     <= '0;
      rgb_q     <= '0;
      key_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_z_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ena_q     <= ena_d;
      opt_q     <= opt_d;
      rga_q     <= rga_d;
      rgb_q     <= rgb_d;
      key_q     <= key_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_z_q   <= rsp_z_d;
      busy_q    <= busy_d;
    end
  end

  assign RSP_VLD = rsp_vld_q;
  assign RSP_ID  = rsp_id_q;
  assign RSP_Z   = rsp_z_q;
  assign ALU_ENA = ena_q;
  assign ALU_OPT = opt_q;
  assign ALU_RGA = rga_q;
  assign ALU_RGB = rgb_q;
  assign ALU_KEY = key_q;
  assign BUSY    = busy_q;

endmodule
